// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and constants for the ALU operand sequencer.
//   - asm_state_e : operand assembler FSM states
//   - entry_t     : one queued ALU operation {mode, cmd, cin, inp_valid, opa, opb}
//   - CMD_MUL_A/B : commands that keep the ALU busy for several cycles
package alu_seq_pkg;

   // Operand width carried in entry_t; the sequencer WIDTH must equal this.
   localparam int SEQ_WIDTH = 8;
   localparam int CMD_W     = 4;

   localparam logic [CMD_W-1:0] CMD_MUL_A = 4'd9;
   localparam logic [CMD_W-1:0] CMD_MUL_B = 4'd10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT_A = 2'd1,
      ST_WAIT_B = 2'd2
   } asm_state_e;

   typedef struct packed {
      logic                 mode;
      logic [CMD_W-1:0]     cmd;
      logic                 cin;
      logic [1:0]           inp_valid;   // {B,A}
      logic [SEQ_WIDTH-1:0] opa;
      logic [SEQ_WIDTH-1:0] opb;
   } entry_t;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// alu_operand_sequencer_if: upstream beat handshake plus the issue bus to the ALU.
//   IN_*  : operation beats (IN_VALID/IN_READY handshake, per-operand valid bits)
//   ALU_* : registered command/operands with the one-cycle ALU_CE strobe
// Modports: slave = sequencer side, master = upstream producer / ALU consumer side.
interface alu_operand_sequencer_if #(
   parameter int WIDTH = 8
);
   logic             IN_VALID;
   logic             IN_READY;
   logic             IN_MODE;
   logic [3:0]       IN_CMD;
   logic             IN_CIN;
   logic             IN_OPA_VLD;
   logic             IN_OPB_VLD;
   logic [WIDTH-1:0] IN_OPA;
   logic [WIDTH-1:0] IN_OPB;

   logic             ALU_CE;
   logic             ALU_MODE;
   logic [3:0]       ALU_CMD;
   logic             ALU_CIN;
   logic [1:0]       ALU_INP_VALID;
   logic [WIDTH-1:0] ALU_OPA;
   logic [WIDTH-1:0] ALU_OPB;

   modport slave (
      input  IN_VALID, IN_MODE, IN_CMD, IN_CIN, IN_OPA_VLD, IN_OPB_VLD, IN_OPA, IN_OPB,
      output IN_READY,
      output ALU_CE, ALU_MODE, ALU_CMD, ALU_CIN, ALU_INP_VALID, ALU_OPA, ALU_OPB
   );

   modport master (
      output IN_VALID, IN_MODE, IN_CMD, IN_CIN, IN_OPA_VLD, IN_OPB_VLD, IN_OPA, IN_OPB,
      input  IN_READY,
      input  ALU_CE, ALU_MODE, ALU_CMD, ALU_CIN, ALU_INP_VALID, ALU_OPA, ALU_OPB
   );
endinterface

// File: rtl/alu_seq_fifo.sv
// alu_seq_fifo: synchronous show-ahead FIFO for queued ALU operations.
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i, wdata_i : write strobe and data (ignored when full)
//   pop_i, rdata_o  : read strobe (ignored when empty); rdata_o is the current head
//   full_o, empty_o : occupancy flags
//   count_o         : current occupancy, 0..DEPTH
module alu_seq_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   push_i,
   input  logic [W-1:0]           wdata_i,
   input  logic                   pop_i,
   output logic [W-1:0]           rdata_o,
   output logic                   full_o,
   output logic                   empty_o,
   output logic [$clog2(DEPTH):0] count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign count_o = count_q;

   // Head is presented combinationally so the issuer can register it on the pop edge.
   assign rdata_o = mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end
endmodule

// File: rtl/alu_operand_sequencer.sv
// alu_operand_sequencer: pairs split operand beats, queues complete operations and
// issues them to the ALU one per cycle, spacing issues after multiply commands.
//   CLK, RST_N  : clock, asynchronous active-low reset
//   bus         : IN_* beat handshake and ALU_* issue outputs (slave modport)
//   TIMEOUT_ERR : one-cycle pulse when a partial operation is pushed after timeout
//   DROP        : one-cycle pulse when an accepted beat is discarded
//   FIFO_COUNT  : current queue occupancy
module alu_operand_sequencer
   import alu_seq_pkg::*;
#(
   parameter int WIDTH   = SEQ_WIDTH,
   parameter int DEPTH   = 4,
   parameter int TIMEOUT = 16,
   parameter int MUL_GAP = 3
) (
   input  logic                    CLK,
   input  logic                    RST_N,
   alu_operand_sequencer_if.slave  bus,
   output logic                    TIMEOUT_ERR,
   output logic                    DROP,
   output logic [$clog2(DEPTH):0]  FIFO_COUNT
);
   localparam int ENTRY_W = 2 * WIDTH + CMD_W + 4;
   localparam int TW      = $clog2(TIMEOUT);
   localparam int GW      = (MUL_GAP > 1) ? $clog2(MUL_GAP) : 1;
   // The timer is cleared on the latching edge, so the push edge is the one at which
   // it would reach TIMEOUT-1: fire while it holds TIMEOUT-2, then saturate.
   localparam logic [TW-1:0] T_FIRE   = TW'(TIMEOUT - 2);
   localparam logic [TW-1:0] T_MAX    = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LOAD = GW'(MUL_GAP - 1);

   asm_state_e    state_q, state_d;
   entry_t        lat_q, lat_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          terr_q, terr_d;
   logic          drop_q, drop_d;

   entry_t        beat;
   entry_t        push_entry;
   entry_t        head;
   entry_t        out_q;
   logic          push;
   logic          accept;
   logic          partner_vld;
   logic          fifo_full;
   logic          fifo_empty;
   logic          issue;
   logic          is_mul;
   logic          ce_q;
   logic [GW-1:0] gap_q;

   assign bus.IN_READY = !fifo_full;
   assign accept       = bus.IN_VALID && bus.IN_READY;

   assign beat.mode      = bus.IN_MODE;
   assign beat.cmd       = bus.IN_CMD;
   assign beat.cin       = bus.IN_CIN;
   assign beat.inp_valid = {bus.IN_OPB_VLD, bus.IN_OPA_VLD};
   assign beat.opa       = bus.IN_OPA;
   assign beat.opb       = bus.IN_OPB;

   // The operand the latched entry is still missing.
   assign partner_vld = (state_q == ST_WAIT_B) ? bus.IN_OPB_VLD : bus.IN_OPA_VLD;

   always_comb begin
      state_d    = state_q;
      lat_d      = lat_q;
      timer_d    = timer_q;
      push       = 1'b0;
      push_entry = beat;
      terr_d     = 1'b0;
      drop_d     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (bus.IN_OPA_VLD == bus.IN_OPB_VLD) begin
                  // Both or neither operand: forward as-is (00 lets the ALU flag ERR).
                  push = 1'b1;
               end else begin
                  lat_d   = beat;
                  timer_d = '0;
                  if (bus.IN_OPA_VLD) begin
                     lat_d.opb = '0;
                     state_d   = ST_WAIT_B;
                  end else begin
                     lat_d.opa = '0;
                     state_d   = ST_WAIT_A;
                  end
               end
            end
         end
         default: begin
            if (accept && partner_vld) begin
               // Accepted implies not full, so the merged push always succeeds.
               push       = 1'b1;
               push_entry = lat_q;
               if (state_q == ST_WAIT_B) push_entry.opb = bus.IN_OPB;
               else                      push_entry.opa = bus.IN_OPA;
               push_entry.inp_valid = 2'b11;
               state_d    = ST_IDLE;
            end else begin
               if (accept) drop_d = 1'b1;
               if (timer_q >= T_FIRE) begin
                  timer_d = T_MAX;
                  if (!fifo_full) begin
                     push       = 1'b1;
                     push_entry = lat_q;
                     terr_d     = 1'b1;
                     state_d    = ST_IDLE;
                  end
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= ST_IDLE;
         lat_q   <= '0;
         timer_q <= '0;
         terr_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lat_q   <= lat_d;
         timer_q <= timer_d;
         terr_q  <= terr_d;
         drop_q  <= drop_d;
      end
   end

   alu_seq_fifo #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (CLK),
      .rst_n   (RST_N),
      .push_i  (push),
      .wdata_i (push_entry),
      .pop_i   (issue),
      .rdata_o (head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (FIFO_COUNT)
   );

   assign issue  = !fifo_empty && (gap_q == '0);
   assign is_mul = head.mode && ((head.cmd == CMD_MUL_A) || (head.cmd == CMD_MUL_B));

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         ce_q  <= 1'b0;
         out_q <= '0;
         gap_q <= '0;
      end else begin
         ce_q <= issue;
         if (issue) begin
            out_q <= head;
            gap_q <= is_mul ? GAP_LOAD : '0;
         end else begin
            // Operands and command hold; only the valid bits fall back to 00.
            out_q.inp_valid <= 2'b00;
            if (gap_q != '0) gap_q <= gap_q - 1'b1;
         end
      end
   end

   assign bus.ALU_CE        = ce_q;
   assign bus.ALU_MODE      = out_q.mode;
   assign bus.ALU_CMD       = out_q.cmd;
   assign bus.ALU_CIN       = out_q.cin;
   assign bus.ALU_INP_VALID = out_q.inp_valid;
   assign bus.ALU_OPA       = out_q.opa;
   assign bus.ALU_OPB       = out_q.opb;
   assign TIMEOUT_ERR       = terr_q;
   assign DROP              = drop_q;
endmodule

// File: tb/tb_alu_operand_sequencer.sv
module tb_alu_operand_sequencer;
   localparam int WIDTH   = 8;
   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 16;
   localparam int MUL_GAP = 3;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       terr;
   logic       drop;
   logic [2:0] fcount;

   alu_operand_sequencer_if #(.WIDTH(WIDTH)) bus ();

   alu_operand_sequencer #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT),
      .MUL_GAP (MUL_GAP)
   ) dut (
      .CLK         (clk),
      .RST_N       (rst_n),
      .bus         (bus),
      .TIMEOUT_ERR (terr),
      .DROP        (drop),
      .FIFO_COUNT  (fcount)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic       mode;
      logic [3:0] cmd;
      logic       cin;
      logic [1:0] iv;
      logic [7:0] a;
      logic [7:0] b;
   } exp_t;

   exp_t exp_q[$];
   int   issue_q[$];
   exp_t mon_e;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic exp_t mk(input logic mode, input logic [3:0] cmd, input logic cin,
                               input logic [1:0] iv, input logic [7:0] a, input logic [7:0] b);
      exp_t e;
      e.mode = mode; e.cmd = cmd; e.cin = cin; e.iv = iv; e.a = a; e.b = b;
      return e;
   endfunction

   // Scoreboard monitor: every issue pops the oldest expected operation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (bus.ALU_CE) begin
            issue_q.push_back(cyc);
            check("issue_pending", exp_q.size() > 0, 1'b1);
            if (exp_q.size() > 0) begin
               mon_e = exp_q.pop_front();
               check("iss_mode", bus.ALU_MODE, mon_e.mode);
               check("iss_cmd", bus.ALU_CMD, mon_e.cmd);
               check("iss_cin", bus.ALU_CIN, mon_e.cin);
               check("iss_inp_valid", bus.ALU_INP_VALID, mon_e.iv);
               if (mon_e.iv[0]) check("iss_opa", bus.ALU_OPA, mon_e.a);
               if (mon_e.iv[1]) check("iss_opb", bus.ALU_OPB, mon_e.b);
            end
         end else begin
            check("idle_inp_valid", bus.ALU_INP_VALID, 2'b00);
         end
      end
   end

   // Drives one beat and holds it until accepted; returns at the negedge after the
   // accepting edge with IN_VALID still high so the next call can follow back-to-back.
   task automatic send(input logic mode, input logic [3:0] cmd, input logic cin,
                       input logic av, input logic bv, input logic [7:0] a, input logic [7:0] b,
                       output int acc_cyc, output int stalls);
      int n;
      bus.IN_VALID   = 1'b1;
      bus.IN_MODE    = mode;
      bus.IN_CMD     = cmd;
      bus.IN_CIN     = cin;
      bus.IN_OPA_VLD = av;
      bus.IN_OPB_VLD = bv;
      bus.IN_OPA     = a;
      bus.IN_OPB     = b;
      n = 0;
      while (!bus.IN_READY && n < 100) begin
         check("stall_count_full", fcount, DEPTH);
         @(negedge clk);
         n++;
      end
      check("accept_bound", n < 100, 1'b1);
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
      stalls  = n;
   endtask

   task automatic idle();
      bus.IN_VALID   = 1'b0;
      bus.IN_OPA_VLD = 1'b0;
      bus.IN_OPB_VLD = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.ALU_CE) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("drain_bound", exp_q.size(), 0);
      repeat (4) @(negedge clk);
   endtask

   initial begin
      int k, st, n, base;
      idle();
      bus.IN_MODE = 1'b0; bus.IN_CMD = 4'd0; bus.IN_CIN = 1'b0;
      bus.IN_OPA  = 8'd0; bus.IN_OPB = 8'd0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ce", bus.ALU_CE, 1'b0);
      check("rst_inp_valid", bus.ALU_INP_VALID, 2'b00);
      check("rst_opa", bus.ALU_OPA, 8'h00);
      check("rst_opb", bus.ALU_OPB, 8'h00);
      check("rst_cmd", bus.ALU_CMD, 4'h0);
      check("rst_terr", terr, 1'b0);
      check("rst_drop", drop, 1'b0);
      check("rst_count", fcount, 3'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_ready", bus.IN_READY, 1'b1);

      // 1: complete beat, one-cycle latency
      send(1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 8'h0F, 8'h01, k, st);
      exp_q.push_back(mk(1'b1, 4'd0, 1'b0, 2'b11, 8'h0F, 8'h01));
      idle();
      @(negedge clk);
      check("t1_ce", bus.ALU_CE, 1'b1);
      check("t1_iv", bus.ALU_INP_VALID, 2'b11);
      check("t1_opa", bus.ALU_OPA, 8'h0F);
      check("t1_opb", bus.ALU_OPB, 8'h01);
      @(negedge clk);
      check("t1_ce_pulse", bus.ALU_CE, 1'b0);
      drain();

      // 2: split pair with a dropped beat in between; B arrives three cycles after A
      send(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 8'h22, 8'h00, k, st);
      idle();
      @(negedge clk);
      send(1'b0, 4'd5, 1'b0, 1'b1, 1'b0, 8'h99, 8'h00, n, st);
      check("t2_drop", drop, 1'b1);
      check("t2_no_issue", bus.ALU_CE, 1'b0);
      send(1'b0, 4'd7, 1'b0, 1'b0, 1'b1, 8'h00, 8'h33, n, st);
      check("t2_b_edge", n - k, 3);
      check("t2_drop_pulse", drop, 1'b0);
      exp_q.push_back(mk(1'b1, 4'd2, 1'b1, 2'b11, 8'h22, 8'h33));
      idle();
      @(negedge clk);
      check("t2_ce", bus.ALU_CE, 1'b1);
      check("t2_opa", bus.ALU_OPA, 8'h22);
      check("t2_opb", bus.ALU_OPB, 8'h33);
      check("t2_cmd", bus.ALU_CMD, 4'd2);
      drain();

      // Neither operand valid: forwarded with INP_VALID=00
      send(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 8'h55, 8'h66, k, st);
      exp_q.push_back(mk(1'b1, 4'd3, 1'b0, 2'b00, 8'h55, 8'h66));
      idle();
      drain();

      // 3: A-only beat with no partner times out
      send(1'b1, 4'd1, 1'b0, 1'b1, 1'b0, 8'h44, 8'h00, k, st);
      exp_q.push_back(mk(1'b1, 4'd1, 1'b0, 2'b01, 8'h44, 8'h00));
      idle();
      n = 0;
      while (!terr && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("t3_terr_seen", terr, 1'b1);
      check("t3_terr_edge", cyc - k, TIMEOUT - 1);
      check("t3_no_early_issue", bus.ALU_CE, 1'b0);
      @(negedge clk);
      check("t3_ce", bus.ALU_CE, 1'b1);
      check("t3_iv", bus.ALU_INP_VALID, 2'b01);
      check("t3_opa", bus.ALU_OPA, 8'h44);
      check("t3_terr_pulse", terr, 1'b0);
      drain();

      // 4: multiply spacing
      issue_q.delete();
      send(1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 8'h03, 8'h05, k, st);
      exp_q.push_back(mk(1'b1, 4'd9, 1'b0, 2'b11, 8'h03, 8'h05));
      send(1'b1, 4'd9, 1'b1, 1'b1, 1'b1, 8'h07, 8'h02, k, st);
      exp_q.push_back(mk(1'b1, 4'd9, 1'b1, 2'b11, 8'h07, 8'h02));
      send(1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 8'h10, 8'h20, k, st);
      exp_q.push_back(mk(1'b1, 4'd0, 1'b0, 2'b11, 8'h10, 8'h20));
      idle();
      n = 0;
      while (issue_q.size() < 3 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("t4_issue_count", issue_q.size() >= 3, 1'b1);
      if (issue_q.size() >= 3) begin
         check("t4_mul_gap", issue_q[1] - issue_q[0], MUL_GAP);
         check("t4_after_mul_gap", issue_q[2] - issue_q[1], MUL_GAP);
      end
      drain();

      // 5: fill the queue behind paced multiplies; seventh beat must wait
      for (int i = 0; i < 6; i++) begin
         send(1'b1, (i % 2 == 0) ? 4'd9 : 4'd10, 1'b0, 1'b1, 1'b1, 8'hA0 + 8'(i), 8'h01, k, st);
         exp_q.push_back(mk(1'b1, (i % 2 == 0) ? 4'd9 : 4'd10, 1'b0, 2'b11, 8'hA0 + 8'(i), 8'h01));
      end
      check("t5_full_count", fcount, 3'd4);
      check("t5_ready_low", bus.IN_READY, 1'b0);
      send(1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 8'hA6, 8'h01, k, st);
      exp_q.push_back(mk(1'b1, 4'd9, 1'b0, 2'b11, 8'hA6, 8'h01));
      check("t5_stall_cycles", st, 2);
      idle();
      drain();

      // 6: reset while in WAIT_B with two queued entries
      base = issue_q.size();
      send(1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 8'h81, 8'h02, k, st);
      exp_q.push_back(mk(1'b1, 4'd9, 1'b0, 2'b11, 8'h81, 8'h02));
      send(1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 8'h82, 8'h02, k, st);
      exp_q.push_back(mk(1'b1, 4'd9, 1'b0, 2'b11, 8'h82, 8'h02));
      send(1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 8'h83, 8'h02, k, st);
      exp_q.push_back(mk(1'b1, 4'd9, 1'b0, 2'b11, 8'h83, 8'h02));
      send(1'b1, 4'd4, 1'b0, 1'b1, 1'b0, 8'h84, 8'h00, k, st);
      idle();
      check("t6_pre_count", fcount, 3'd2);
      #2;
      rst_n = 1'b0;
      #1;
      exp_q.delete();
      check("t6_rst_ce", bus.ALU_CE, 1'b0);
      check("t6_rst_opa", bus.ALU_OPA, 8'h00);
      check("t6_rst_opb", bus.ALU_OPB, 8'h00);
      check("t6_rst_cmd", bus.ALU_CMD, 4'h0);
      check("t6_rst_mode", bus.ALU_MODE, 1'b0);
      check("t6_rst_count", fcount, 3'd0);
      check("t6_rst_terr", terr, 1'b0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (TIMEOUT + 8) @(negedge clk);
      check("t6_post_count", fcount, 3'd0);
      check("t6_post_ready", bus.IN_READY, 1'b1);
      check("t6_no_stale_issue", issue_q.size() - base, 1);
      check("t6_post_terr", terr, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
